// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and reset-value map for the integer and FP register files.
package utils;

    localparam logic [31:0] STACK_SIZE  = 32'h0000_1000;
    localparam logic [31:0] GLOBAL_SIZE = 32'h0001_0000;
    localparam logic [31:0] FT1_INIT    = 32'h3f80_0000;

    localparam int ZERO = 0;
    localparam int FT1  = 1;
    localparam int SP   = 2;
    localparam int GP   = 3;
    localparam int HP   = 4;

    function automatic logic [31:0] init_value(input logic fpu, input int idx);
        if (fpu) begin
            return (idx == FT1) ? FT1_INIT : 32'h0;
        end
        case (idx)
            SP:      return STACK_SIZE - 32'd1;
            HP:      return GLOBAL_SIZE;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback and issue signals of the register file; master drives requests.
interface regfile_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 64,
    parameter int NREAD  = 3,
    parameter int NWRITE = 2
);
    localparam int AW = $clog2(NREG);

    logic [NREAD-1:0][AW-1:0]    rd_addr;
    logic [NREAD-1:0][XLEN-1:0]  rd_data;
    logic [NREAD-1:0]            rd_busy;
    logic [NWRITE-1:0]           wr_en;
    logic [NWRITE-1:0][AW-1:0]   wr_addr;
    logic [NWRITE-1:0][XLEN-1:0] wr_data;
    logic                        issue_en;
    logic [AW-1:0]               issue_addr;
    logic                        issue_ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, issue_ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, issue_ready
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register in-flight counter: one increment, up to 2^DW-1 decrements, clamped to [0, 2^CW-1].
module sb_counter #(
    parameter int CW = 2,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic          sat,
    output logic          pending
);
    localparam int SW = ((CW > DW) ? CW : DW) + 2;
    localparam logic [CW-1:0] MAXC = '1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] post_s, nxt_s;

    function automatic logic [CW-1:0] clamp(input logic signed [SW-1:0] v);
        if (v < 0) return '0;
        if (v > $signed(SW'(MAXC))) return MAXC;
        return v[CW-1:0];
    endfunction

    // Busy reflects the count after this cycle's writebacks but before this cycle's issue.
    always_comb begin
        post_s  = $signed(SW'(cnt_q)) - $signed(SW'(dec));
        nxt_s   = post_s + $signed(SW'(inc));
        cnt_d   = clamp(nxt_s);
        pending = (post_s > 0);
        sat     = (cnt_q == MAXC);
    end

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port flop register file with write-to-read bypass and per-register RAW scoreboard.
module regfile_scoreboard
    import utils::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 64,
    parameter int NREAD  = 3,
    parameter int NWRITE = 2,
    parameter int FPU    = 0,
    parameter int BYPASS = 1,
    parameter int CW     = 2
) (
    input  logic clk,
    input  logic rstn,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int DW = $clog2(NWRITE + 1);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [DW-1:0]   dec_cnt [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] sat;
    logic [NREG-1:0] pending;

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        inc    = '0;
        for (int r = 0; r < NREG; r++) dec_cnt[r] = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (bus.wr_en[w] && bus.wr_addr[w] != '0) begin
                regs_d[bus.wr_addr[w]]  = bus.wr_data[w];
                dec_cnt[bus.wr_addr[w]] = dec_cnt[bus.wr_addr[w]] + DW'(1);
            end
        end
        if (bus.issue_en && bus.issue_addr != '0) inc[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= XLEN'(init_value(FPU != 0, r));
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        sb_counter #(.CW(CW), .DW(DW)) u_cnt (
            .clk     (clk),
            .rstn    (rstn),
            .inc     (inc[r]),
            .dec     (dec_cnt[r]),
            .sat     (sat[r]),
            .pending (pending[r])
        );
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] rd;
        for (int i = 0; i < NREAD; i++) begin
            a  = bus.rd_addr[i];
            rd = regs_q[a];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w] == a) rd = bus.wr_data[w];
                end
            end
            if (a == '0) rd = '0;
            bus.rd_data[i] = rd;
            bus.rd_busy[i] = pending[a];
        end
    end

    // A same-cycle writeback frees a slot, so a saturated register can still accept an issue.
    assign bus.issue_ready = (bus.issue_addr == '0) || !sat[bus.issue_addr] ||
                             (dec_cnt[bus.issue_addr] != '0);

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(bus.issue_en && !bus.issue_ready))
                else $error("issue to saturated register %0d dropped", bus.issue_addr);
        end
    end

endmodule
